// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root arbiter: flag and type encodings, FSM states and
// operand classification helpers.
package sqrt_pkg;

  localparam logic [2:0] FLAG_DENORM   = 3'b000;
  localparam logic [2:0] FLAG_ZERO     = 3'b001;
  localparam logic [2:0] FLAG_INF      = 3'b010;
  localparam logic [2:0] FLAG_NAN      = 3'b011;
  localparam logic [2:0] FLAG_NORMAL   = 3'b100;
  localparam logic [2:0] FLAG_SIGN_ERR = 3'b111;

  localparam logic TYPE_SINGLE = 1'b0;
  localparam logic TYPE_DOUBLE = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Zero, inf and nan pass straight through with their own exponent and flags.
  function automatic logic is_special(logic [2:0] flags);
    return (flags == FLAG_ZERO) || (flags == FLAG_INF) || (flags == FLAG_NAN);
  endfunction

  // Negative finite operands and upstream sign errors resolve to a sign-error response.
  function automatic logic is_sign_err(logic sign, logic [2:0] flags);
    return (flags == FLAG_SIGN_ERR) ||
           (sign && ((flags == FLAG_DENORM) || (flags == FLAG_NORMAL)));
  endfunction

endpackage

// File: rtl/sqrt_arb_rr.sv
// Two-requester round-robin grant. The pointer moves to the requester that was not served
// once the served transaction completes its response handshake.
module sqrt_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       idle,
  input  logic       advance,
  output logic       grant,
  output logic [1:0] ready
);

  logic ptr_q;
  logic owner_q;

  // Pointer requester wins; the other one is granted only when the pointer side is quiet.
  always_comb begin
    grant    = valid[ptr_q] ? ptr_q : ~ptr_q;
    ready[0] = idle & valid[0] & ~grant;
    ready[1] = idle & valid[1] & grant;
  end

  // Remember who was accepted so the pointer can skip past it on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      if (|ready) begin
        owner_q <= grant;
      end
      if (advance) begin
        ptr_q <= ~owner_q;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Arbiter/sequencer sharing one FP square-root core between two requesters. Special-case
// operands are answered without starting the core. Optional BUSY watchdog is enabled by
// defining SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter int unsigned EXP_SIZE       = 11,
  parameter int unsigned M_SIZE         = 53,
  parameter int unsigned RES_M_SIZE     = 53,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_sign,
  input  logic [EXP_SIZE-1:0]   req0_exp,
  input  logic [M_SIZE-1:0]     req0_mantisa,
  input  logic [2:0]            req0_flags,
  input  logic                  req0_type,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_sign,
  input  logic [EXP_SIZE-1:0]   req1_exp,
  input  logic [M_SIZE-1:0]     req1_mantisa,
  input  logic [2:0]            req1_flags,
  input  logic                  req1_type,
  output logic                  sq_start,
  output logic                  sq_sign,
  output logic [EXP_SIZE-1:0]   sq_exp,
  output logic [M_SIZE-1:0]     sq_mantisa,
  output logic [2:0]            sq_flags,
  output logic                  sq_type,
  input  logic                  sq_done,
  input  logic [EXP_SIZE-1:0]   sq_res_exp,
  input  logic [RES_M_SIZE-1:0] sq_res_mantisa,
  input  logic [2:0]            sq_res_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic                  rsp_sign,
  output logic [EXP_SIZE-1:0]   rsp_exp,
  output logic [RES_M_SIZE-1:0] rsp_mantisa,
  output logic [2:0]            rsp_flags,
  output logic                  rsp_type
);

  arb_state_e state_q;

  logic                grant;
  logic [1:0]          ready;
  logic                accept;
  logic                sel_sign;
  logic [EXP_SIZE-1:0] sel_exp;
  logic [M_SIZE-1:0]   sel_mant;
  logic [2:0]          sel_flags;
  logic                sel_type;

  sqrt_arb_rr u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid}),
    .idle    (state_q == StIdle),
    .advance ((state_q == StResp) & rsp_valid & rsp_ready),
    .grant   (grant),
    .ready   (ready)
  );

  // Operand fields of whichever requester currently holds the grant.
  always_comb begin
    req0_ready = ready[0];
    req1_ready = ready[1];
    accept     = |ready;
    sel_sign   = grant ? req1_sign    : req0_sign;
    sel_exp    = grant ? req1_exp     : req0_exp;
    sel_mant   = grant ? req1_mantisa : req0_mantisa;
    sel_flags  = grant ? req1_flags   : req0_flags;
    sel_type   = grant ? req1_type    : req0_type;
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_cnt_q;

  // Counts BUSY cycles; cleared on the way into BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StIssue) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == StBusy) && !sq_done) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Sequencer FSM; every output it drives is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sq_start    <= 1'b0;
      sq_sign     <= 1'b0;
      sq_exp      <= '0;
      sq_mantisa  <= '0;
      sq_flags    <= '0;
      sq_type     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_sign    <= 1'b0;
      rsp_exp     <= '0;
      rsp_mantisa <= '0;
      rsp_flags   <= '0;
      rsp_type    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rsp_id   <= grant;
            rsp_type <= sel_type;
            if (is_special(sel_flags)) begin
              state_q     <= StResp;
              rsp_valid   <= 1'b1;
              rsp_sign    <= sel_sign;
              rsp_exp     <= sel_exp;
              rsp_mantisa <= '0;
              rsp_flags   <= sel_flags;
            end else if (is_sign_err(sel_sign, sel_flags)) begin
              state_q     <= StResp;
              rsp_valid   <= 1'b1;
              rsp_sign    <= 1'b1;
              rsp_exp     <= '0;
              rsp_mantisa <= '0;
              rsp_flags   <= FLAG_SIGN_ERR;
            end else begin
              state_q    <= StIssue;
              sq_start   <= 1'b1;
              sq_sign    <= sel_sign;
              sq_exp     <= sel_exp;
              sq_mantisa <= sel_mant;
              sq_flags   <= sel_flags;
              sq_type    <= sel_type;
            end
          end
        end
        StIssue: begin
          sq_start <= 1'b0;
          state_q  <= StBusy;
        end
        StBusy: begin
          if (sq_done) begin
            state_q     <= StResp;
            rsp_valid   <= 1'b1;
            rsp_sign    <= 1'b0;
            rsp_exp     <= sq_res_exp;
            rsp_mantisa <= sq_res_mantisa;
            rsp_flags   <= sq_res_flags;
            rsp_type    <= sq_type;
          end
`ifdef SQRT_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TmoMax) begin
            // Core never answered: report nan and abandon the operation.
            state_q     <= StResp;
            rsp_valid   <= 1'b1;
            rsp_sign    <= 1'b0;
            rsp_exp     <= '0;
            rsp_mantisa <= '0;
            rsp_flags   <= FLAG_NAN;
            rsp_type    <= sq_type;
          end
`endif
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a response scoreboard. Define SQRT_ARB_TIMEOUT_EN
// for both RTL and bench to include the watchdog scenario.
module tb_sqrt_arbiter;

  localparam int unsigned EXP_SIZE = 11;
  localparam int unsigned M_SIZE = 53;
  localparam int unsigned RES_M_SIZE = 53;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_valid = 0, req0_sign = 0, req0_type = 0;
  logic req1_valid = 0, req1_sign = 0, req1_type = 0;
  logic [EXP_SIZE-1:0] req0_exp = '0, req1_exp = '0;
  logic [M_SIZE-1:0] req0_mantisa = '0, req1_mantisa = '0;
  logic [2:0] req0_flags = '0, req1_flags = '0;
  logic req0_ready, req1_ready;
  logic sq_start, sq_sign, sq_type;
  logic [EXP_SIZE-1:0] sq_exp;
  logic [M_SIZE-1:0] sq_mantisa;
  logic [2:0] sq_flags;
  logic sq_done = 1'b0;
  logic [EXP_SIZE-1:0] sq_res_exp = '0;
  logic [RES_M_SIZE-1:0] sq_res_mantisa = '0;
  logic [2:0] sq_res_flags = '0;
  logic rsp_valid, rsp_id, rsp_sign, rsp_type;
  logic rsp_ready = 1'b0;
  logic [EXP_SIZE-1:0] rsp_exp;
  logic [RES_M_SIZE-1:0] rsp_mantisa;
  logic [2:0] rsp_flags;

  // Result the bench's core model returns for the next started operation.
  logic [EXP_SIZE-1:0] core_exp = '0;
  logic [RES_M_SIZE-1:0] core_mant = '0;
  logic [2:0] core_flags = '0;

  always #5 clk = ~clk;

  sqrt_arbiter #(
    .EXP_SIZE       (EXP_SIZE),
    .M_SIZE         (M_SIZE),
    .RES_M_SIZE     (RES_M_SIZE),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_sign      (req0_sign),
    .req0_exp       (req0_exp),
    .req0_mantisa   (req0_mantisa),
    .req0_flags     (req0_flags),
    .req0_type      (req0_type),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_sign      (req1_sign),
    .req1_exp       (req1_exp),
    .req1_mantisa   (req1_mantisa),
    .req1_flags     (req1_flags),
    .req1_type      (req1_type),
    .sq_start       (sq_start),
    .sq_sign        (sq_sign),
    .sq_exp         (sq_exp),
    .sq_mantisa     (sq_mantisa),
    .sq_flags       (sq_flags),
    .sq_type        (sq_type),
    .sq_done        (sq_done),
    .sq_res_exp     (sq_res_exp),
    .sq_res_mantisa (sq_res_mantisa),
    .sq_res_flags   (sq_res_flags),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_sign       (rsp_sign),
    .rsp_exp        (rsp_exp),
    .rsp_mantisa    (rsp_mantisa),
    .rsp_flags      (rsp_flags),
    .rsp_type       (rsp_type)
  );

  typedef struct {
    logic                  id;
    logic                  sign;
    logic [EXP_SIZE-1:0]   exp;
    logic [RES_M_SIZE-1:0] mant;
    logic [2:0]            flags;
    logic                  typ;
  } rsp_t;

  rsp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected response for an operand, written from the operation rules.
  function automatic rsp_t model(logic id, logic s, logic [EXP_SIZE-1:0] e, logic [2:0] f,
                                 logic t);
    rsp_t r;
    r.id  = id;
    r.typ = t;
    if (f == 3'b001 || f == 3'b010 || f == 3'b011) begin
      r.sign = s; r.exp = e; r.mant = '0; r.flags = f;
    end else if (f == 3'b111 || (s && (f == 3'b000 || f == 3'b100))) begin
      r.sign = 1'b1; r.exp = '0; r.mant = '0; r.flags = 3'b111;
    end else begin
      r.sign = 1'b0; r.exp = core_exp; r.mant = core_mant; r.flags = core_flags;
    end
    return r;
  endfunction

  task automatic set_req(input int k, input logic s, input logic [EXP_SIZE-1:0] e,
                         input logic [M_SIZE-1:0] m, input logic [2:0] f, input logic t);
    if (k == 0) begin
      req0_sign = s; req0_exp = e; req0_mantisa = m; req0_flags = f; req0_type = t;
      req0_valid = 1'b1;
    end else begin
      req1_sign = s; req1_exp = e; req1_mantisa = m; req1_flags = f; req1_type = t;
      req1_valid = 1'b1;
    end
  endtask

  // Pop the next expected response and check it; rsp_ready stays low for 'hold' cycles first.
  task automatic collect(input string tag, input int hold);
    rsp_t e;
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_exp"}, rsp_exp, e.exp);
      check({tag, "_hold_flags"}, rsp_flags, e.flags);
      check({tag, "_hold_no_accept"}, req0_ready | req1_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_id"}, rsp_id, e.id);
    check({tag, "_sign"}, rsp_sign, e.sign);
    check({tag, "_exp"}, rsp_exp, e.exp);
    check({tag, "_mant"}, rsp_mantisa, e.mant);
    check({tag, "_flags"}, rsp_flags, e.flags);
    check({tag, "_type"}, rsp_type, e.typ);
    step();
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, rsp_valid, 0);
  endtask

  // One full transaction with whatever requests are currently offered.
  task automatic txn(input string tag, input int exp_id, input bit drop, input int hold);
    int k;
    logic s, t;
    logic [EXP_SIZE-1:0] ex;
    logic [M_SIZE-1:0] m;
    logic [2:0] f;
    bit byp;
    k = -1;
    for (int i = 0; i < 20; i++) begin
      #2;
      check({tag, "_one_ready"}, req0_ready & req1_ready, 0);
      if (req0_ready) k = 0;
      else if (req1_ready) k = 1;
      if (k >= 0) break;
      step();
    end
    check({tag, "_grant_seen"}, 64'(k >= 0), 64'd1);
    if (k < 0) return;
    check({tag, "_grant_id"}, k, exp_id);
    if (k == 0) begin
      s = req0_sign; ex = req0_exp; m = req0_mantisa; f = req0_flags; t = req0_type;
    end else begin
      s = req1_sign; ex = req1_exp; m = req1_mantisa; f = req1_flags; t = req1_type;
    end
    exp_q.push_back(model(k[0], s, ex, f, t));
    byp = (f == 3'b001 || f == 3'b010 || f == 3'b011 || f == 3'b111) || s;
    @(posedge clk);
    #1;
    if (drop) begin
      if (k == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
    if (byp) begin
      check({tag, "_byp_no_start"}, sq_start, 0);
      check({tag, "_byp_rsp_valid"}, rsp_valid, 1);
    end else begin
      check({tag, "_start"}, sq_start, 1);
      check({tag, "_sq_exp"}, sq_exp, ex);
      check({tag, "_sq_mant"}, sq_mantisa, m);
      step();
      check({tag, "_start_one_cycle"}, sq_start, 0);
      step();
      step();
      check({tag, "_busy_no_rsp"}, rsp_valid, 0);
      check({tag, "_busy_sq_exp"}, sq_exp, ex);
      sq_done = 1'b1; sq_res_exp = core_exp; sq_res_mantisa = core_mant;
      sq_res_flags = core_flags;
      step();
      sq_done = 1'b0;
      check({tag, "_done_rsp_valid"}, rsp_valid, 1);
    end
    collect(tag, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_sq_start", sq_start, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_flags", rsp_flags, 0);
    check("reset_sq_exp", sq_exp, 0);
    check("reset_ready", req0_ready | req1_ready, 0);
    rst = 1'b1;
    step();

    // Normal operand through the core.
    core_exp = 11'h3FF; core_mant = 53'h10_0000_0000_0001; core_flags = 3'b100;
    set_req(0, 1'b0, 11'h400, 53'h18_0000_0000_0000, 3'b100, 1'b1);
    txn("t1_normal", 0, 1'b1, 0);

    // Negative normal from req1: sign-error bypass.
    set_req(1, 1'b1, 11'h400, 53'h12_3456_789A_BCDE, 3'b100, 1'b0);
    txn("t2_sign_err", 1, 1'b1, 0);

    // Both requesters continuously valid: order 0,1,0.
    set_req(0, 1'b0, 11'h3F0, 53'h1F_0000_0000_00AA, 3'b100, 1'b1);
    set_req(1, 1'b0, 11'h010, 53'h00_0F00_0000_0055, 3'b000, 1'b0);
    core_exp = 11'h1F8; core_mant = 53'h16_A09E_667F_3BCD; core_flags = 3'b100;
    txn("arb_a", 0, 1'b0, 0);
    core_exp = 11'h208; core_mant = 53'h00_0ABC_0000_1234; core_flags = 3'b000;
    txn("arb_b", 1, 1'b0, 0);
    core_exp = 11'h2AA; core_mant = 53'h1A_5A5A_5A5A_5A5A; core_flags = 3'b100;
    txn("arb_c", 0, 1'b0, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Negative infinity passes through with its sign.
    set_req(0, 1'b1, 11'h7FF, 53'h1F_FFFF_FFFF_FFFF, 3'b010, 1'b1);
    txn("t_inf", 0, 1'b1, 0);

    // Stalled response: req0 waits while req1's nan response is held.
    set_req(0, 1'b0, 11'h300, 53'h11_1111_1111_1111, 3'b100, 1'b0);
    set_req(1, 1'b0, 11'h7FF, 53'h08_0000_0000_0000, 3'b011, 1'b1);
    core_exp = 11'h37F; core_mant = 53'h13_3333_3333_3333; core_flags = 3'b100;
    txn("stall", 1, 1'b1, 5);
    txn("after_stall", 0, 1'b1, 0);

    // Reset while the core is busy; the late completion must be dropped.
    set_req(0, 1'b0, 11'h456, 53'h15_5555_5555_5555, 3'b100, 1'b1);
    #2;
    check("rst_mid_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    check("rst_mid_start", sq_start, 1);
    step();
    rst = 1'b0;
    step();
    check("rst_mid_sq_exp", sq_exp, 0);
    check("rst_mid_sq_start", sq_start, 0);
    rst = 1'b1;
    step();
    step();
    sq_done = 1'b1; sq_res_exp = 11'h123; sq_res_mantisa = 53'h1; sq_res_flags = 3'b100;
    step();
    sq_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_done_no_rsp", rsp_valid, 0);
      step();
    end
    check("late_done_rsp_exp", rsp_exp, 0);
    check("late_done_rsp_flags", rsp_flags, 0);
    // Pointer back to requester 0 after reset.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    check("rst_ptr_r0", req0_ready, 1);
    check("rst_ptr_r1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

`ifdef SQRT_ARB_TIMEOUT_EN
    // Core never completes: nan response after 8 BUSY cycles.
    set_req(0, 1'b0, 11'h400, 53'h18_0000_0000_0000, 3'b100, 1'b1);
    #2;
    check("tmo_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    check("tmo_start", sq_start, 1);
    for (int i = 0; i < 8; i++) step();
    check("tmo_not_yet", rsp_valid, 0);
    step();
    check("tmo_rsp_valid", rsp_valid, 1);
    begin
      rsp_t e;
      e.id = 1'b0; e.sign = 1'b0; e.exp = '0; e.mant = '0; e.flags = 3'b011; e.typ = 1'b1;
      exp_q.push_back(e);
    end
    collect("tmo", 0);
    sq_done = 1'b1;
    step();
    sq_done = 1'b0;
    step();
    check("tmo_late_done", rsp_valid, 0);
`endif

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
